// File: rtl/dram_cache_pkg.sv
// Shared types and helpers for the direct-mapped write-back DRAM record cache.
package dram_cache_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 64;

  typedef enum logic [3:0] {
    StIdle,
    StHitRsp,
    StWbIssue,
    StWbWait,
    StFillIssue,
    StFillWait,
    StMissRsp,
    StFlushScan,
    StFlushIssue,
    StFlushWait,
    StFlushDone
  } state_e;

  // Tag is kept at full address width; its upper bits are simply zero.
  typedef struct packed {
    logic              valid;
    logic              dirty;
    logic [ADDR_W-1:0] tag;
    logic [DATA_W-1:0] data;
  } line_t;

  function automatic logic [ADDR_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr,
                                                 input int unsigned       idx_w);
    return addr >> idx_w;
  endfunction

  function automatic logic [ADDR_W-1:0] addr_index(input logic [ADDR_W-1:0] addr,
                                                   input int unsigned       idx_w);
    logic [ADDR_W-1:0] mask;
    mask = '1;
    mask = ~(mask << idx_w);
    return addr & mask;
  endfunction

  function automatic logic [ADDR_W-1:0] join_addr(input logic [ADDR_W-1:0] tag,
                                                  input logic [ADDR_W-1:0] idx,
                                                  input int unsigned       idx_w);
    return (tag << idx_w) | idx;
  endfunction

endpackage

// File: rtl/dram_wb_cache.sv
// Direct-mapped write-back cache of 64-bit records in front of the single-beat DRAM bridge.
// Misses write back a dirty victim first, then fill (reads) or install directly (writes).
module dram_wb_cache
  import dram_cache_pkg::*;
#(
  parameter int unsigned N_LINES = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  input  logic              i_req_wr,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_req_ready,
  output logic              o_rsp_valid,
  output logic [DATA_W-1:0] o_rsp_rdata,
  input  logic              i_flush_valid,
  output logic              o_flush_done,
  output logic              o_c_in_valid,
  output logic              o_c_r_wb,
  output logic [ADDR_W-1:0] o_c_addr,
  output logic [DATA_W-1:0] o_c_data_w,
  input  logic              i_c_out_valid,
  input  logic [DATA_W-1:0] i_c_data_r
);

  localparam int unsigned IDX_W = (N_LINES > 1) ? $clog2(N_LINES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_LINES - 1);

  state_e            r_state, w_state_d;
  line_t             r_lines [N_LINES];
  logic [ADDR_W-1:0] r_addr;
  logic              r_wr;
  logic [DATA_W-1:0] r_wdata;
  logic [IDX_W-1:0]  r_scan, w_scan_d;
  logic              r_flush_pend, w_flush_pend_d;

  logic [ADDR_W-1:0] w_req_tag;
  logic [IDX_W-1:0]  w_req_idx, w_cur_idx, w_line_idx;
  line_t             w_req_line, w_cur_line, w_scan_line, w_line_d;
  logic              w_line_we, w_accept;

  assign w_req_tag   = addr_tag(i_req_addr, IDX_W);
  assign w_req_idx   = IDX_W'(addr_index(i_req_addr, IDX_W));
  assign w_cur_idx   = IDX_W'(addr_index(r_addr, IDX_W));
  assign w_req_line  = r_lines[w_req_idx];
  assign w_cur_line  = r_lines[w_cur_idx];
  assign w_scan_line = r_lines[r_scan];

  always_comb begin
    w_state_d      = r_state;
    w_scan_d       = r_scan;
    w_flush_pend_d = r_flush_pend | i_flush_valid;
    w_line_we      = 1'b0;
    w_line_idx     = w_cur_idx;
    w_line_d       = w_cur_line;
    w_accept       = 1'b0;
    case (r_state)
      StIdle: begin
        if (i_flush_valid || r_flush_pend) begin
          w_flush_pend_d = 1'b0;
          w_scan_d       = '0;
          w_state_d      = StFlushScan;
        end else if (i_req_valid) begin
          w_accept   = 1'b1;
          w_line_idx = w_req_idx;
          if (w_req_line.valid && (w_req_line.tag == w_req_tag)) begin
            w_state_d = StHitRsp;
            if (i_req_wr) begin
              w_line_we      = 1'b1;
              w_line_d       = w_req_line;
              w_line_d.data  = i_req_wdata;
              w_line_d.dirty = 1'b1;
            end
          end else if (w_req_line.valid && w_req_line.dirty) begin
            w_state_d = StWbIssue;
          end else if (i_req_wr) begin
            w_line_we = 1'b1;
            w_line_d  = '{valid: 1'b1, dirty: 1'b1, tag: w_req_tag, data: i_req_wdata};
            w_state_d = StMissRsp;
          end else begin
            w_state_d = StFillIssue;
          end
        end
      end
      StHitRsp, StMissRsp, StFlushDone: w_state_d = StIdle;
      StWbIssue:    w_state_d = StWbWait;
      StWbWait: begin
        if (i_c_out_valid) begin
          if (r_wr) begin
            w_line_we = 1'b1;
            w_line_d  = '{valid: 1'b1, dirty: 1'b1, tag: addr_tag(r_addr, IDX_W), data: r_wdata};
            w_state_d = StMissRsp;
          end else begin
            w_state_d = StFillIssue;
          end
        end
      end
      StFillIssue:  w_state_d = StFillWait;
      StFillWait: begin
        if (i_c_out_valid) begin
          w_line_we = 1'b1;
          w_line_d  = '{valid: 1'b1, dirty: 1'b0, tag: addr_tag(r_addr, IDX_W), data: i_c_data_r};
          w_state_d = StMissRsp;
        end
      end
      StFlushScan: begin
        if (w_scan_line.valid && w_scan_line.dirty) begin
          w_state_d = StFlushIssue;
        end else if (r_scan == LAST_IDX) begin
          w_state_d = StFlushDone;
        end else begin
          w_scan_d = r_scan + IDX_W'(1);
        end
      end
      StFlushIssue: w_state_d = StFlushWait;
      StFlushWait: begin
        if (i_c_out_valid) begin
          w_line_we      = 1'b1;
          w_line_idx     = r_scan;
          w_line_d       = w_scan_line;
          w_line_d.dirty = 1'b0;
          if (r_scan == LAST_IDX) begin
            w_state_d = StFlushDone;
          end else begin
            w_scan_d  = r_scan + IDX_W'(1);
            w_state_d = StFlushScan;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_scan       <= '0;
      r_flush_pend <= 1'b0;
      r_addr       <= '0;
      r_wr         <= 1'b0;
      r_wdata      <= '0;
      for (int i = 0; i < int'(N_LINES); i++) begin
        r_lines[i].valid <= 1'b0;
        r_lines[i].dirty <= 1'b0;
      end
    end else begin
      r_state      <= w_state_d;
      r_scan       <= w_scan_d;
      r_flush_pend <= w_flush_pend_d;
      if (w_accept) begin
        r_addr  <= i_req_addr;
        r_wr    <= i_req_wr;
        r_wdata <= i_req_wdata;
      end
      if (w_line_we) r_lines[w_line_idx] <= w_line_d;
    end
  end

  // Ready is gated by reset so every output reads 0 while reset is held.
  assign o_req_ready  = i_rst_n && (r_state == StIdle) && !r_flush_pend && !i_flush_valid;
  assign o_rsp_valid  = (r_state == StHitRsp) || (r_state == StMissRsp);
  assign o_rsp_rdata  = (o_rsp_valid && !r_wr) ? w_cur_line.data : '0;
  assign o_flush_done = (r_state == StFlushDone);

  // Bridge fields are decoded from state, so they hold through *_WAIT and drop with it.
  always_comb begin
    o_c_in_valid = 1'b0;
    o_c_r_wb     = 1'b0;
    o_c_addr     = '0;
    o_c_data_w   = '0;
    case (r_state)
      StWbIssue, StWbWait: begin
        o_c_in_valid = (r_state == StWbIssue);
        o_c_addr     = join_addr(w_cur_line.tag, ADDR_W'(w_cur_idx), IDX_W);
        o_c_data_w   = w_cur_line.data;
      end
      StFillIssue, StFillWait: begin
        o_c_in_valid = (r_state == StFillIssue);
        o_c_r_wb     = 1'b1;
        o_c_addr     = r_addr;
      end
      StFlushIssue, StFlushWait: begin
        o_c_in_valid = (r_state == StFlushIssue);
        o_c_addr     = join_addr(w_scan_line.tag, ADDR_W'(r_scan), IDX_W);
        o_c_data_w   = w_scan_line.data;
      end
      default: ;
    endcase
  end

endmodule
